micro_sequencer: RTL
====================

Name: micro_sequencer

Overview:
- Microprogram sequencer that drives the 8-bit address of the control ROM and interprets each 16-bit ROM word as one microinstruction.
- Handles sequencing, conditional branches, subroutine call/return, opcode dispatch, and the start/done handshake with the host.
- Sits between the instruction-fetch logic and the datapath. It forwards the per-microinstruction control strobes to the datapath.

Parameters:
- STACK_DEPTH, 4, number of entries in the return-address stack (1..8).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a microprogram; sampled only in IDLE.
- entry_addr  in  8  first microinstruction address, captured with start.
- opcode  in  8  dispatch target used by DISPATCH.
- cond  in  4  datapath condition flags.
- stall  in  1  freeze sequencing for this cycle.
- abort  in  1  synchronous return to IDLE from any state.
- rom_addr  out  8  address to the control ROM; equals the uPC register.
- rom_word  in  16  combinational ROM data for rom_addr.
- ctrl_out  out  3  datapath strobes, rom_word[2:0], gated.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after END executes.
- fault  out  1  high in FAULT.

Behaviour:
Clocking and reset:
- One clock: clk.
- Reset rst is asynchronous and active-high.
- On reset: state=IDLE, uPC=0, sp=0, done=0. Hence rom_addr=0, ctrl_out=0, busy=0, fault=0.

Microinstruction word fields:
- [15:13] op.
- [12:11] csel: selects cond[csel].
- [10:3] target address.
- [2:0] strobes.

Op encoding:
- 000 NEXT: uPC <= uPC+1.
- 001 JUMP: uPC <= target.
- 010 BRT: uPC <= cond[csel] ? target : uPC+1.
- 011 BRF: uPC <= !cond[csel] ? target : uPC+1.
- 100 CALL: push uPC+1; uPC <= target.
- 101 RET: uPC <= top; pop.
- 110 DISPATCH: uPC <= opcode.
- 111 END: uPC <= 0; state <= IDLE; done <= 1 next cycle.

Address arithmetic:
- uPC+1 is 8-bit and wraps 255 -> 0 with no fault.

States:
- IDLE:
  - uPC held; ctrl_out=0.
  - If start=1: uPC <= entry_addr, state <= RUN.
  - The first microinstruction executes the cycle after start.
- RUN:
  - Each non-stalled cycle executes the word at uPC.
  - ctrl_out = rom_word[2:0] in the same cycle (combinational, one microinstruction per clock).
  - busy=1.
  - start is ignored.
- FAULT:
  - Entered on CALL with sp==STACK_DEPTH (overflow), or on RET with sp==0 (underflow).
  - uPC is not updated and the stack is unchanged.
  - ctrl_out=0; fault=1 sticky. Only abort or rst leaves FAULT.

Stall:
- In RUN with stall=1: uPC, sp, and state hold; ctrl_out=0.
- The same word re-executes when stall drops.
- cond is evaluated only in the executing (non-stalled) cycle.

Abort:
- abort=1 in any state: next state IDLE, uPC=0, sp=0, no done pulse.
- abort has priority over stall, start, and the current op.
- ctrl_out=0 in the abort cycle.

done:
- Registered. High exactly one cycle, the cycle after END executes (first IDLE cycle).
- If start=1 in that same IDLE cycle, it is accepted.

Stack:
- LIFO of 8-bit entries with STACK_DEPTH entries.
- Contents are not cleared on abort or reset; only sp resets.

Test Plan:
1. Sequential/END:
   - Stimulus: ROM 0x10 NEXT strobes=3'b101, 0x11 END; start, entry_addr=0x10.
   - Required: rom_addr 0x10 then 0x11; ctrl_out 5 then rom[0x11][2:0]; done pulses one cycle; busy drops; rom_addr=0.
2. Branch:
   - Stimulus: BRT csel=2 target=0x40 at 0x20, with cond=4'b0100, then rerun with cond=0.
   - Required: next rom_addr 0x40 in the first run, 0x21 in the second.
3. Call/return nesting:
   - Stimulus: CALL 0x80 at 0x30; CALL 0x90 at 0x80; RET at 0x90 and at 0x81.
   - Required: address trace 0x30, 0x80, 0x90, 0x81, 0x31.
4. Stack faults:
   - Stimulus: five nested CALLs with STACK_DEPTH=4; separately, RET at sp=0.
   - Required: fault=1 and rom_addr frozen at the faulting word; abort -> IDLE, fault=0, sp=0.
5. Stall/abort:
   - Stimulus: stall for 3 cycles on a JUMP.
   - Required: rom_addr unchanged and ctrl_out=0 for those cycles, then jump taken.
   - Stimulus: abort together with stall mid-program.
   - Required: IDLE next cycle, no done pulse.
6. Dispatch/wrap/reset:
   - Stimulus: DISPATCH with opcode=0xC3.
   - Required: rom_addr=0xC3.
   - Stimulus: NEXT at 0xFF.
   - Required: rom_addr=0x00.
   - Stimulus: rst asserted mid-RUN.
   - Required: outputs immediately at reset values without a clock edge.

Source files
------------

// File: rtl/micro_sequencer.sv
// micro_sequencer: control-ROM microprogram sequencer with call stack, branches, dispatch and host handshake
// Ports:
//   clk, rst                 clock, async active-high reset
//   start, entry_addr        host launch request and first microinstruction address
//   opcode                   DISPATCH target
//   cond                     datapath condition flags selected by csel
//   stall, abort             freeze sequencing / return to IDLE
//   rom_addr, rom_word       control ROM address (uPC) and its combinational data
//   ctrl_out                 gated datapath strobes rom_word[2:0]
//   busy, done, fault        RUN indicator, end-of-program pulse, stack fault flag
module micro_sequencer #(
  parameter int STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  entry_addr,
  input  logic [7:0]  opcode,
  input  logic [3:0]  cond,
  input  logic        stall,
  input  logic        abort,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_word,
  output logic [2:0]  ctrl_out,
  output logic        busy,
  output logic        done,
  output logic        fault
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JUMP = 3'd1;
  localparam logic [2:0] OP_BRT  = 3'd2;
  localparam logic [2:0] OP_BRF  = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_DISP = 3'd6;
  localparam logic [2:0] OP_END  = 3'd7;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT} state_t;
  state_t           r_state;
  logic [7:0]       r_upc;
  logic [SPW-1:0]   r_sp;
  logic             r_done;
  logic [7:0]       r_stack [STACK_DEPTH];
  logic [2:0]       w_op;
  logic [7:0]       w_tgt;
  logic [7:0]       w_inc;
  logic [7:0]       w_next;
  logic             w_take;
  logic             w_exec;
  logic             w_full;
  logic             w_empty;
  logic             w_fault_now;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;
  assign w_op        = rom_word[15:13];
  assign w_tgt       = rom_word[10:3];
  assign w_take      = cond[rom_word[12:11]];
  assign w_inc       = r_upc + 8'd1;
  assign w_full      = (r_sp == SPW'(STACK_DEPTH));
  assign w_empty     = (r_sp == '0);
  assign w_wr_idx    = AW'(r_sp);
  assign w_rd_idx    = AW'(r_sp - 1'b1);
  // abort and stall both suppress execution of the word at uPC
  assign w_exec      = (r_state == S_RUN) && !stall && !abort;
  assign w_fault_now = ((w_op == OP_CALL) && w_full) || ((w_op == OP_RET) && w_empty);
  assign rom_addr    = r_upc;
  assign ctrl_out    = w_exec ? rom_word[2:0] : 3'b000;
  assign busy        = (r_state == S_RUN);
  assign fault       = (r_state == S_FAULT);
  assign done        = r_done;
  always_comb begin
    w_next = w_inc;
    case (w_op)
      OP_NEXT: w_next = w_inc;
      OP_JUMP: w_next = w_tgt;
      OP_BRT:  w_next = w_take ? w_tgt : w_inc;
      OP_BRF:  w_next = w_take ? w_inc : w_tgt;
      OP_CALL: w_next = w_tgt;
      OP_RET:  w_next = r_stack[w_rd_idx];
      OP_DISP: w_next = opcode;
      OP_END:  w_next = 8'h00;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_upc   <= 8'h00;
      r_sp    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        r_upc   <= 8'h00;
        r_sp    <= '0;
      end else if (r_state == S_IDLE && start) begin
        r_upc   <= entry_addr;
        r_state <= S_RUN;
      end else if (w_exec) begin
        if (w_fault_now) begin
          // faulting word stays at rom_addr for inspection; stack untouched
          r_state <= S_FAULT;
        end else begin
          r_upc <= w_next;
          if (w_op == OP_CALL) r_sp <= r_sp + 1'b1;
          if (w_op == OP_RET) r_sp <= r_sp - 1'b1;
          if (w_op == OP_END) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
      end
    end
  end
  // stack contents are deliberately not reset; only sp is
  always_ff @(posedge clk) begin
    if (w_exec && w_op == OP_CALL && !w_full) r_stack[w_wr_idx] <= w_inc;
  end
endmodule
